// File: rtl/serial_rx_cubestate_pkg.sv
// Shared types and constants for the cubestate UART receiver: color codes,
// frame constants, and the bit-level and frame-level FSM encodings.
package serial_rx_cubestate_pkg;

  localparam int         CUBESTATE_W       = 162;
  localparam int         CLKS_PER_BIT_DEF  = 217;
  localparam logic [7:0] SYNC_BYTE_DEF     = 8'hA5;
  localparam int         PAYLOAD_BYTES_DEF = 21;

  typedef enum logic [2:0] {
    COLOR_W = 3'd0,
    COLOR_O = 3'd1,
    COLOR_G = 3'd2,
    COLOR_R = 3'd3,
    COLOR_B = 3'd4,
    COLOR_Y = 3'd5
  } color_e;

  typedef enum logic [1:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP
  } bit_state_e;

  typedef enum logic [1:0] {
    FRM_HUNT,
    FRM_PAYLOAD,
    FRM_CHECK
  } frame_state_e;

  // True when every 3-bit sticker field holds a real color (0..5).
  function automatic logic colors_legal(input logic [CUBESTATE_W-1:0] state);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < CUBESTATE_W / 3; i++) begin
      if (state[3*i +: 3] > COLOR_Y) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/serial_rx_cubestate_uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchronizer on rx_pin, start-bit glitch
// rejection, and a stop-bit check that reports framing errors.
module uart_rx_byte
  import serial_rx_cubestate_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_pin,
  output logic [7:0] data_byte,
  output logic       byte_strobe,
  output logic       framing_err,
  output logic       bit_busy
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync_q;
  logic             rx_sync;
  logic             rx_prev;
  bit_state_e       state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  assign rx_sync  = sync_q[1];
  assign bit_busy = (state != BIT_IDLE);

  // Synchronizer and edge-detect history idle high so reset never looks like a start bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], rx_pin};
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BIT_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data_byte   <= '0;
      byte_strobe <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      framing_err <= 1'b0;
      case (state)
        BIT_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state   <= BIT_START;
            clk_cnt <= '0;
          end
        end
        BIT_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? BIT_IDLE : BIT_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        BIT_DATA: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= BIT_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        BIT_STOP: begin
          // Decide at mid-stop and go idle right away so back-to-back bytes are caught.
          if (clk_cnt == FULL_LAST) begin
            clk_cnt <= '0;
            state   <= BIT_IDLE;
            if (rx_sync) begin
              data_byte   <= shift;
              byte_strobe <= 1'b1;
            end else begin
              framing_err <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= BIT_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/serial_rx_cubestate.sv
// Receives a framed 162-bit cubestate (sync, 21 payload bytes, XOR checksum).
// Define CUBE_RX_COLOR_CHECK_EN to also reject frames holding sticker codes 6 or 7.
module serial_rx_cubestate
  import serial_rx_cubestate_pkg::*;
#(
  parameter int         CLKS_PER_BIT  = CLKS_PER_BIT_DEF,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF,
  parameter int         PAYLOAD_BYTES = PAYLOAD_BYTES_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   rx_pin,
  output logic [CUBESTATE_W-1:0] cubestate,
  output logic                   cube_valid,
  output logic                   frame_error,
  output logic                   busy,
  output logic [4:0]             byte_count
);

  localparam int         SHIFT_W    = 8 * PAYLOAD_BYTES;
  localparam logic [4:0] COUNT_MAX  = 5'(PAYLOAD_BYTES);
  localparam logic [4:0] COUNT_LAST = 5'(PAYLOAD_BYTES - 1);

  logic [7:0]         rx_byte;
  logic               rx_strobe;
  logic               rx_ferr;
  logic               bit_busy;
  frame_state_e       frame_state;
  logic [SHIFT_W-1:0] shift_reg;
  logic [7:0]         checksum_acc;
  logic               colors_ok;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_rx (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx_pin     (rx_pin),
    .data_byte  (rx_byte),
    .byte_strobe(rx_strobe),
    .framing_err(rx_ferr),
    .bit_busy   (bit_busy)
  );

`ifdef CUBE_RX_COLOR_CHECK_EN
  assign colors_ok = colors_legal(shift_reg[CUBESTATE_W-1:0]);
`else
  assign colors_ok = 1'b1;
`endif

  assign busy = (frame_state != FRM_HUNT) || bit_busy;

  // Frame FSM; cube_valid and frame_error are one-cycle pulses a cycle after the byte strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_state  <= FRM_HUNT;
      shift_reg    <= '0;
      checksum_acc <= '0;
      byte_count   <= '0;
      cubestate    <= '0;
      cube_valid   <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      cube_valid  <= 1'b0;
      frame_error <= 1'b0;
      case (frame_state)
        FRM_HUNT: begin
          if (rx_strobe && rx_byte == SYNC_BYTE) begin
            byte_count   <= '0;
            checksum_acc <= '0;
            frame_state  <= FRM_PAYLOAD;
          end
        end
        FRM_PAYLOAD: begin
          if (rx_ferr) begin
            frame_error <= 1'b1;
            frame_state <= FRM_HUNT;
          end else if (rx_strobe) begin
            shift_reg    <= {shift_reg[SHIFT_W-9:0], rx_byte};
            checksum_acc <= checksum_acc ^ rx_byte;
            if (byte_count < COUNT_MAX) byte_count <= byte_count + 1'b1;
            if (byte_count == COUNT_LAST) frame_state <= FRM_CHECK;
          end
        end
        FRM_CHECK: begin
          if (rx_ferr) begin
            frame_error <= 1'b1;
            frame_state <= FRM_HUNT;
          end else if (rx_strobe) begin
            frame_state <= FRM_HUNT;
            if (rx_byte == checksum_acc && colors_ok) begin
              cubestate  <= shift_reg[CUBESTATE_W-1:0];
              cube_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
          end
        end
        default: frame_state <= FRM_HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx_cubestate.sv
// Self-checking bench for serial_rx_cubestate: table-driven frames, a scoreboard
// of expected accept/reject events, and hand-written corner-case sequences.
module tb_serial_rx_cubestate;

  localparam int CLKS          = 24;
  localparam int PAYLOAD_BYTES = 21;
`ifdef CUBE_RX_COLOR_CHECK_EN
  localparam bit COLOR_CHK = 1'b1;
`else
  localparam bit COLOR_CHK = 1'b0;
`endif

  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic         rx_pin  = 1'b1;
  logic [161:0] cubestate;
  logic         cube_valid;
  logic         frame_error;
  logic         busy;
  logic [4:0]   byte_count;

  int checks = 0;
  int errors = 0;
  int strobe_count = 0;

  typedef struct {
    logic         is_valid;
    logic [161:0] state;
  } exp_t;

  typedef struct {
    logic [167:0] payload;
    logic [7:0]   chk_mask;
    logic         exp_ok;
  } vec_t;

  exp_t         sb_q[$];
  exp_t         sb_head;
  vec_t         vecs[6];
  logic [161:0] model_state = '0;

  serial_rx_cubestate #(
    .CLKS_PER_BIT (CLKS),
    .SYNC_BYTE    (8'hA5),
    .PAYLOAD_BYTES(PAYLOAD_BYTES)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx_pin     (rx_pin),
    .cubestate  (cubestate),
    .cube_valid (cube_valid),
    .frame_error(frame_error),
    .busy       (busy),
    .byte_count (byte_count)
  );

  always #20 clock = ~clock;

  task automatic checkOutput(input string name, input logic [167:0] act, input logic [167:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every accept/reject pulse must match the oldest expectation.
  always @(negedge clock) begin
    if (dut.u_byte_rx.byte_strobe) strobe_count++;
    if (cube_valid || frame_error) begin
      checkOutput("valid_error_exclusive", 168'(cube_valid & frame_error), 168'd0);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_event: got valid=%b error=%b, required no event",
                 cube_valid, frame_error);
      end else begin
        sb_head = sb_q.pop_front();
        checkOutput("event_kind_valid", 168'(cube_valid), 168'(sb_head.is_valid));
        checkOutput("cubestate_at_event", 168'(cubestate), 168'(sb_head.state));
      end
    end
  end

  function automatic logic [7:0] xor_bytes(input logic [167:0] p);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < PAYLOAD_BYTES; i++) x ^= p[8*i +: 8];
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clock);
    rx_pin = 1'b0;
    repeat (CLKS) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (CLKS) @(negedge clock);
    end
    rx_pin = stop_bit;
    repeat (CLKS) @(negedge clock);
    rx_pin = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic push_expect(input logic ok, input logic [161:0] state);
    exp_t e;
    if (ok) model_state = state;
    e.is_valid = ok;
    e.state    = model_state;
    sb_q.push_back(e);
  endtask

  // Sends sync, payload MSB byte first, then checksum; expectation queued before the checksum.
  task automatic applyStimulus(input logic [167:0] payload, input logic [7:0] checksum, input logic exp_ok);
    send_byte(8'hA5, 1'b1);
    for (int i = PAYLOAD_BYTES - 1; i >= 0; i--) send_byte(payload[8*i +: 8], 1'b1);
    push_expect(exp_ok, payload[161:0]);
    send_byte(checksum, 1'b1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 4 * CLKS) begin
      @(negedge clock);
      n++;
    end
    checkOutput(name, 168'(sb_q.size()), 168'd0);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_cubestate"}, 168'(cubestate), 168'd0);
    checkOutput({tag, "_cube_valid"}, 168'(cube_valid), 168'd0);
    checkOutput({tag, "_frame_error"}, 168'(frame_error), 168'd0);
    checkOutput({tag, "_busy"}, 168'(busy), 168'd0);
    checkOutput({tag, "_byte_count"}, 168'(byte_count), 168'd0);
  endtask

  initial begin
    logic [167:0] pattern;
    int s0;

    pattern = '0;
    for (int i = 0; i < 54; i++) pattern[3*i +: 3] = 3'(i % 6);
    pattern[167:162] = 6'h3F;
    vecs[0] = '{168'h1, 8'h00, 1'b1};
    vecs[1] = '{168'h1, 8'h01, 1'b0};
    vecs[2] = '{pattern, 8'h00, 1'b1};
    vecs[3] = '{pattern, 8'h80, 1'b0};
    vecs[4] = '{168'h7, 8'h00, !COLOR_CHK};
    vecs[5] = '{168'hA500, 8'h00, 1'b1};

    repeat (5) @(negedge clock);
    check_reset_values("reset");
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].payload, xor_bytes(vecs[v].payload) ^ vecs[v].chk_mask, vecs[v].exp_ok);
      wait_drain($sformatf("vec%0d_drain", v));
      checkOutput($sformatf("vec%0d_byte_count", v), 168'(byte_count), 168'd21);
      checkOutput($sformatf("vec%0d_cubestate_hold", v), 168'(cubestate), 168'(model_state));
    end

    // Non-sync bytes in HUNT are dropped without leaving HUNT.
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    repeat (2) @(negedge clock);
    checkOutput("hunt_busy_idle", 168'(busy), 168'd0);
    checkOutput("hunt_count_kept", 168'(byte_count), 168'd21);
    applyStimulus(168'h2, 8'h02, 1'b1);
    wait_drain("after_hunt_drain");

    // Framing error on payload byte 5 aborts the frame.
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'h11, 1'b1);
    push_expect(1'b0, '0);
    send_byte(8'h22, 1'b0);
    wait_drain("abort_drain");
    repeat (CLKS) @(negedge clock);
    checkOutput("abort_busy", 168'(busy), 168'd0);
    applyStimulus(168'h3, 8'h03, 1'b1);
    wait_drain("after_abort_drain");

    // Short glitches on the idle line must not produce a byte.
    s0 = strobe_count;
    @(negedge clock);
    rx_pin = 1'b0;
    @(negedge clock);
    rx_pin = 1'b1;
    repeat (3 * CLKS) @(negedge clock);
    checkOutput("glitch1_busy", 168'(busy), 168'd0);
    rx_pin = 1'b0;
    repeat (CLKS / 3) @(negedge clock);
    rx_pin = 1'b1;
    repeat (3 * CLKS) @(negedge clock);
    checkOutput("glitch2_busy", 168'(busy), 168'd0);
    checkOutput("glitch_no_strobe", 168'(strobe_count - s0), 168'd0);

    // Reset mid-payload discards the partial frame.
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'h33, 1'b1);
    checkOutput("partial_byte_count", 168'(byte_count), 168'd5);
    reset_n = 1'b0;
    model_state = '0;
    #1;
    check_reset_values("midreset");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    applyStimulus(168'h4, 8'h04, 1'b1);
    wait_drain("after_reset_drain");

    repeat (2 * CLKS) @(negedge clock);
    checkOutput("final_queue_empty", 168'(sb_q.size()), 168'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
